rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between N writeback requesters
//  (ALU stage, multi-cycle unit) via valid/ready handshakes; registers the winning write.
//  Keeps a pending-write scoreboard so decode can stall on RAW hazards for Rs1/Rs2.
//  Sits between execute/writeback sources and the register file (Reg_W_En/Rd/writedata).
// PARAMETERS
//  ADDR_LEN      3   register address width
//  DATA_WIDTH    16  write data width
//  REG_FILE_SIZE 8   number of registers (scoreboard depth)
//  N_REQ         2   number of writeback requesters (>=2); index 0 = highest fixed priority
// PORTS
//  clk          in   1                  clock, all state on rising edge
//  nReset       in   1                  synchronous active-low reset
//  req_valid    in   N_REQ              requester i has a write pending
//  req_rd       in   N_REQ*ADDR_LEN     destination register, slice i
//  req_data     in   N_REQ*DATA_WIDTH   write data, slice i
//  req_ready    out  N_REQ              one-hot grant; transfer = valid&ready
//  sb_alloc     in   1                  decode issued an instr that will write sb_alloc_rd
//  sb_alloc_rd  in   ADDR_LEN           register to mark pending
//  Rs1, Rs2     in   ADDR_LEN           decode source registers to check
//  busy1, busy2 out  1                  source has a pending (unretired) write
//  stall        out  1                  busy1|busy2
//  Reg_W_En     out  1                  registered write enable to register file
//  Rd           out  ADDR_LEN           registered write address
//  writedata    out  DATA_WIDTH         registered write data
// BEHAVIOUR
//  - Reset (nReset=0 at posedge): Reg_W_En=0, Rd=0, writedata=0, scoreboard all clear,
//    arbitration pointer=0. req_ready/busy/stall are combinational; 0 while scoreboard clear
//    and no req_valid. Reset mid-transfer drops the in-flight write; no write reaches regfile.
//  - Arbitration: combinational, at most one req_ready high per cycle; ready only to a
//    valid requester; no valid -> req_ready=0. Losers hold valid/rd/data stable until granted.
//  - Latency: transfer in cycle t -> Reg_W_En=1 with that Rd/data in cycle t+1 (one pulse).
//    No transfer in t -> Reg_W_En=0 in t+1; Rd/writedata hold last value.
//  - Rd==0 transfer: handshake completes, Reg_W_En stays 0, scoreboard untouched.
//  - Scoreboard: bit r set on sb_alloc (r=sb_alloc_rd, r!=0); cleared on transfer with
//    req_rd=r. Same-cycle alloc and clear of same r -> bit stays set (new producer wins).
//    Alloc of already-set bit: remains set (single outstanding writer per reg assumed by issue).
//  - busy1 = sb[Rs1] & (Rs1!=0); busy2 likewise; reflects registered state (clear visible
//    the cycle after transfer, aligned with Reg_W_En write, so regfile data is valid then).
//  - Widths: no arithmetic; index slices as [i*W +: W].
// CONFIGURATION
//  RF_WB_RR_ARB_EN defined: round-robin; pointer advances to (granted index+1) mod N_REQ
//    after each transfer; search starts at pointer. Pointer unchanged on idle cycles.
//  RF_WB_RR_ARB_EN undefined: fixed priority, lowest valid index wins; pointer logic absent.
// STRUCTURE
//  rf_pkg: ADDR_LEN/DATA_WIDTH/REG_FILE_SIZE localparams, typedef rf_addr_t, rf_data_t,
//    struct wb_req_t {rd, data}.
//  Sub-module rf_scoreboard: set/clear bit vector + two read ports (busy1/busy2).
//  Top: arbiter (comb) + output registers + rf_scoreboard instance.
// TESTING
//  1 Reset: drive nReset=0 with req_valid=2'b11 -> Reg_W_En=0, Rd=0, writedata=0, busy=0.
//  2 Single: req0 rd=3 data=16'hBEEF -> req_ready=01 same cycle; next cycle Reg_W_En=1,Rd=3,writedata=BEEF.
//  3 Contention: both valid (rd 2/5) 4 cycles -> fixed: req0 always granted, req1 starves;
//    RR_EN: grants alternate 01,10,01,10.
//  4 Scoreboard: sb_alloc rd=4, Rs1=4 -> busy1=1,stall=1 until cycle after rd=4 transfer -> 0.
//  5 Same-cycle alloc+clear rd=6 -> bit stays set, busy on Rs2=6 next cycle = 1.
//  6 Rd=0: transfer rd=0 data=FFFF -> ready=1, Reg_W_En stays 0; alloc rd=0 -> busy never set.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback path.
// Consumers: rf_scoreboard, rf_wb_arbiter and its testbench.
package rf_pkg;

    localparam int ADDR_LEN      = 3;
    localparam int DATA_WIDTH    = 16;
    localparam int REG_FILE_SIZE = 8;

    typedef logic [ADDR_LEN-1:0]   rf_addr_t;
    typedef logic [DATA_WIDTH-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t rd;
        rf_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared when the matching writeback retires; two read ports for decode.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     nReset,
    input  logic     set_en,
    input  rf_addr_t set_rd,
    input  logic     clr_en,
    input  rf_addr_t clr_rd,
    input  rf_addr_t rs1,
    input  rf_addr_t rs2,
    output logic     busy1,
    output logic     busy2
);

    logic [REG_FILE_SIZE-1:0] pend_reg;
    logic [REG_FILE_SIZE-1:0] pend_next;

    generate
        for (genvar gi = 0; gi < REG_FILE_SIZE; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                // Register 0 is hardwired, so it can never have a pending writer.
                assign pend_next[gi] = 1'b0;
            end else begin : g_live
                logic hit_set;
                logic hit_clr;
                assign hit_set = set_en && (set_rd == rf_addr_t'(gi));
                assign hit_clr = clr_en && (clr_rd == rf_addr_t'(gi));
                // A same-cycle alloc beats the clear: the new producer still owes a write.
                assign pend_next[gi] = hit_set | (pend_reg[gi] & ~hit_clr);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!nReset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    assign busy1 = pend_reg[rs1] & (rs1 != '0);
    assign busy2 = pend_reg[rs2] & (rs2 != '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with RAW scoreboard. Fixed priority by default;
// define RF_WB_RR_ARB_EN for round-robin arbitration.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                        clk,
    input  logic                        nReset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_LEN-1:0]   req_rd,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        sb_alloc,
    input  logic [ADDR_LEN-1:0]         sb_alloc_rd,
    input  logic [ADDR_LEN-1:0]         Rs1,
    input  logic [ADDR_LEN-1:0]         Rs2,
    output logic                        busy1,
    output logic                        busy2,
    output logic                        stall,
    output logic                        Reg_W_En,
    output logic [ADDR_LEN-1:0]         Rd,
    output logic [DATA_WIDTH-1:0]       writedata
);

    wb_req_t          req_arr [N_REQ];
    logic [N_REQ-1:0] grant;
    wb_req_t          win;
    logic             xfer;
    logic             wr_fire;

    logic             w_en_reg;
    rf_addr_t         rd_reg;
    rf_data_t         data_reg;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_arr[gi] = {req_rd[gi*ADDR_LEN +: ADDR_LEN],
                                  req_data[gi*DATA_WIDTH +: DATA_WIDTH]};
        end
    endgenerate

`ifdef RF_WB_RR_ARB_EN
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] win_idx;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (grant == '0 && req_valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (xfer) begin
            ptr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == '0 && req_valid[i]) begin
                grant[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win = req_arr[i];
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    // Writes to register 0 complete the handshake but never reach the regfile.
    assign wr_fire   = xfer && (win.rd != '0);

    always_ff @(posedge clk) begin
        if (!nReset) begin
            w_en_reg <= 1'b0;
            rd_reg   <= '0;
            data_reg <= '0;
        end else begin
            w_en_reg <= wr_fire;
            if (wr_fire) begin
                rd_reg   <= win.rd;
                data_reg <= win.data;
            end
        end
    end

    assign Reg_W_En  = w_en_reg;
    assign Rd        = rd_reg;
    assign writedata = data_reg;

    rf_scoreboard u_scoreboard (
        .clk    (clk),
        .nReset (nReset),
        .set_en (sb_alloc && (sb_alloc_rd != '0)),
        .set_rd (sb_alloc_rd),
        .clr_en (wr_fire),
        .clr_rd (win.rd),
        .rs1    (Rs1),
        .rs2    (Rs2),
        .busy1  (busy1),
        .busy2  (busy2)
    );

    assign stall = busy1 | busy2;

endmodule
